// File: rtl/mmio_timer_slave.sv
// mmio_timer_slave
// Memory-mapped timer slave: prescaled up-counter with compare match (one-shot or
// auto-reload), overflow flag, write-1-to-clear status and a level interrupt.
// Register select comes from address[4:2]; read data is combinational and gated by re.

module mmio_timer_slave #(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  irq
);

  localparam logic [2:0] SEL_CTRL     = 3'd0;
  localparam logic [2:0] SEL_PRESCALE = 3'd1;
  localparam logic [2:0] SEL_COMPARE  = 3'd2;
  localparam logic [2:0] SEL_COUNT    = 3'd3;
  localparam logic [2:0] SEL_STATUS   = 3'd4;

  localparam logic [DATA_WIDTH-1:0]     COUNT_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0]     COUNT_ONE  = DATA_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE    = PRESCALE_WIDTH'(1);

  logic [2:0] reg_sel;

  logic wr_ctrl;
  logic wr_prescale;
  logic wr_compare;
  logic wr_count;
  logic wr_status;

  logic                      ctrl_en;
  logic                      ctrl_auto_reload;
  logic                      ctrl_irq_en;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [DATA_WIDTH-1:0]     compare;
  logic [DATA_WIDTH-1:0]     count;
  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic                      st_match;
  logic                      st_ovf;

  logic                      tick;
  logic                      count_hit;
  logic                      count_max;
  logic                      match_set;
  logic                      ovf_set;
  logic                      oneshot_stop;

  logic [DATA_WIDTH-1:0]     count_next;
  logic [PRESCALE_WIDTH-1:0] pre_cnt_next;
  logic                      match_next;
  logic                      ovf_next;
  logic [DATA_WIDTH-1:0]     rd_mux;

  logic unused_address_bits;

  assign reg_sel = address[4:2];

  assign unused_address_bits = ^{address[DATA_WIDTH-1:5], address[1:0]};

  assign wr_ctrl     = we && (reg_sel == SEL_CTRL);
  assign wr_prescale = we && (reg_sel == SEL_PRESCALE);
  assign wr_compare  = we && (reg_sel == SEL_COMPARE);
  assign wr_count    = we && (reg_sel == SEL_COUNT);
  assign wr_status   = we && (reg_sel == SEL_STATUS);

  // The tick and the compare/overflow events all come from the registered state of this cycle.
  always_comb begin
    tick         = ctrl_en && (pre_cnt == prescale);
    count_hit    = (count == compare);
    count_max    = (count == COUNT_ONES);
    match_set    = tick && count_hit;
    ovf_set      = tick && !count_hit && count_max;
    oneshot_stop = match_set && !ctrl_auto_reload;
  end

  // Prescaler: a software write to CTRL or PRESCALE restarts the period from zero.
  always_comb begin
    pre_cnt_next = pre_cnt;
    if (wr_ctrl || wr_prescale) begin
      pre_cnt_next = '0;
    end else if (ctrl_en) begin
      if (pre_cnt == prescale) begin
        pre_cnt_next = '0;
      end else begin
        pre_cnt_next = pre_cnt + PRE_ONE;
      end
    end
  end

  // Counter update: a software write beats the tick; compare match takes priority over overflow.
  always_comb begin
    count_next = count;
    if (wr_count) begin
      count_next = wd;
    end else if (tick) begin
      if (count_hit) begin
        if (ctrl_auto_reload) begin
          count_next = '0;
        end
      end else if (count_max) begin
        count_next = '0;
      end else begin
        count_next = count + COUNT_ONE;
      end
    end
  end

  // Status flags: a hardware set in the same cycle as a write-1-to-clear leaves the flag at 1.
  always_comb begin
    match_next = st_match;
    ovf_next   = st_ovf;
    if (wr_status && wd[0]) begin
      match_next = 1'b0;
    end
    if (wr_status && wd[1]) begin
      ovf_next = 1'b0;
    end
    if (match_set) begin
      match_next = 1'b1;
    end
    if (ovf_set) begin
      ovf_next = 1'b1;
    end
  end

  // Control register: the software value wins over the one-shot stop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en          <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      ctrl_irq_en      <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en          <= wd[0];
      ctrl_auto_reload <= wd[1];
      ctrl_irq_en      <= wd[2];
    end else if (oneshot_stop) begin
      ctrl_en          <= 1'b0;
    end
  end

  // Configuration registers written only by software.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      compare  <= '0;
    end else begin
      if (wr_prescale) begin
        prescale <= wd[PRESCALE_WIDTH-1:0];
      end
      if (wr_compare) begin
        compare <= wd;
      end
    end
  end

  // Counting state: prescaler, counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      count    <= '0;
      st_match <= 1'b0;
      st_ovf   <= 1'b0;
    end else begin
      pre_cnt  <= pre_cnt_next;
      count    <= count_next;
      st_match <= match_next;
      st_ovf   <= ovf_next;
    end
  end

  // Read mux shows the pre-edge register values, so a same-cycle write reads back the old value.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      SEL_CTRL:     rd_mux = DATA_WIDTH'({ctrl_irq_en, ctrl_auto_reload, ctrl_en});
      SEL_PRESCALE: rd_mux = DATA_WIDTH'(prescale);
      SEL_COMPARE:  rd_mux = compare;
      SEL_COUNT:    rd_mux = count;
      SEL_STATUS:   rd_mux = DATA_WIDTH'({st_ovf, st_match});
      default:      rd_mux = '0;
    endcase
  end

  assign rd  = re ? rd_mux : '0;
  assign irq = (st_match || st_ovf) && ctrl_irq_en;

endmodule
